program_loader: RTL and testbench

- Upstream stage of the processor: streams a program image byte-by-byte into the 16-bit instruction memory, then releases the CPU to run.
- Holds the CPU's active-low reset (`cpu_resetn`) low while loading; sets it high only after a checksum-verified load.
- Image format, big-endian: length word (2 bytes) + N instruction words (2N bytes) + 1 checksum byte.

---
 rtl/processor_pkg.sv | 24 ++
 rtl/program_loader.sv | 188 ++++++++++++++++++
 tb/tb_program_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared types and image-format constants for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package processor_pkg;

    // Loader FSM states, 4-bit encoding.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    // Image framing: big-endian length word ahead of the payload, one
    // XOR checksum byte after it.
    localparam int IMG_HDR_BYTES = 2;
    localparam int CHK_BYTES     = 1;

endpackage

// File: rtl/program_loader.sv
// Streams a program image (len word, N big-endian words, XOR checksum) into instruction memory, holding the CPU in reset until a verified load.
// Latency: each word is written 1 cycle after its low byte is accepted; done/error rise on the edge that accepts the checksum byte.
// Backpressure: byte_ready is registered and state-only; byte_valid low stalls indefinitely, no timeout.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   start                 - one-cycle pulse, honoured only in IDLE/DONE/ERROR
//   byte_valid/byte_ready - byte handshake, transfer when both are 1 at a clock edge
//   byte_data             - image byte
//   mem_we/mem_addr/mem_wdata - instruction memory write port (one-cycle strobe)
//   cpu_resetn            - processor reset, 1 only after a successful load
//   busy/done/error       - load status
module program_loader
    import processor_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_resetn,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Largest legal length is a completely full memory.
    localparam logic [16:0]       LEN_MAX  = 17'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t            state, state_nxt;
    logic [7:0]        len_hi, len_hi_nxt;
    logic [ADDR_W:0]   len_words, len_words_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic [7:0]        hi, hi_nxt;
    logic [7:0]        chk, chk_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       wdata_nxt;
    logic              byte_ready_nxt;
    logic              mem_we_nxt;
    logic              cpu_resetn_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              error_nxt;

    logic              xfer;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   cnt_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_hi     <= '0;
            len_words  <= '0;
            cnt        <= '0;
            hi         <= '0;
            chk        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            cpu_resetn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            len_hi     <= len_hi_nxt;
            len_words  <= len_words_nxt;
            cnt        <= cnt_nxt;
            hi         <= hi_nxt;
            chk        <= chk_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            byte_ready <= byte_ready_nxt;
            mem_we     <= mem_we_nxt;
            cpu_resetn <= cpu_resetn_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        len_hi_nxt    = len_hi;
        len_words_nxt = len_words;
        cnt_nxt       = cnt;
        hi_nxt        = hi;
        chk_nxt       = chk;
        addr_nxt      = mem_addr;
        wdata_nxt     = mem_wdata;

        // byte_ready is a registered copy of "state accepts bytes", so
        // this is exactly the handshake the producer sees.
        xfer     = byte_valid & byte_ready;
        len_full = {len_hi, byte_data};
        cnt_inc  = cnt + CNT_ONE;

        // Every accepted byte, framing included, folds into the checksum.
        if (xfer) begin
            chk_nxt = chk ^ byte_data;
        end

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = LEN_HI;
                    chk_nxt   = '0;
                    addr_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_hi_nxt = byte_data;
                    state_nxt  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_words_nxt = len_full[ADDR_W:0];
                    if ({1'b0, len_full} > LEN_MAX) begin
                        state_nxt = ERROR;
                    end else if (len_full == 16'd0) begin
                        state_nxt = CHK;
                    end else begin
                        state_nxt = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    hi_nxt    = byte_data;
                    state_nxt = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    wdata_nxt = {hi, byte_data};
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // Address wraps to 0 only after the word at the top of memory.
                addr_nxt = mem_addr + ADDR_ONE;
                cnt_nxt  = cnt_inc;
                if (cnt_inc == len_words) begin
                    state_nxt = CHK;
                end else begin
                    state_nxt = DATA_HI;
                end
            end
            CHK: begin
                if (xfer) begin
                    if ((chk ^ byte_data) == 8'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ERROR;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Status outputs are functions of the next state so that they are
        // registered alongside it; busy falls on the edge done/error rise.
        byte_ready_nxt = (state_nxt == LEN_HI) || (state_nxt == LEN_LO) ||
                         (state_nxt == DATA_HI) || (state_nxt == DATA_LO) ||
                         (state_nxt == CHK);
        mem_we_nxt     = (state_nxt == WRITE);
        busy_nxt       = (state_nxt != IDLE) && (state_nxt != DONE) &&
                         (state_nxt != ERROR);
        done_nxt       = (state_nxt == DONE);
        error_nxt      = (state_nxt == ERROR);
        cpu_resetn_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    import processor_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_resetn;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Log of every memory write observed on the write port.
    logic [7:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];

    program_loader #(.ADDR_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_resetn (cpu_resetn),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input int idx, input logic [7:0] a, input logic [15:0] d);
        logic [7:0]  oa;
        logic [15:0] od;
        oa = 8'hxx;
        od = 16'hxxxx;
        if (idx < wr_addr_q.size()) begin
            oa = wr_addr_q[idx];
            od = wr_data_q[idx];
        end
        check($sformatf("wr%0d_addr", idx), {24'd0, oa}, {24'd0, a});
        check($sformatf("wr%0d_data", idx), {16'd0, od}, {16'd0, d});
    endtask

    // Offer one byte and wait (bounded) for it to be taken. Returns #1
    // after the accepting edge with byte_valid dropped.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        n = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                byte_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("accept", {31'd0, byte_ready}, 32'd1);
        if (byte_ready === 1'b1) begin
            @(posedge clock);
            #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[7:0], gaps);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        check({tag, "_cpu_resetn"}, {31'd0, cpu_resetn}, 32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_error"},      {31'd0, error},      32'd0);
        check({tag, "_mem_addr"},   {24'd0, mem_addr},   32'd0);
        check({tag, "_mem_wdata"},  {16'd0, mem_wdata},  32'd0);
        check({tag, "_state"},      {28'd0, dut.state},  {28'd0, IDLE});
    endtask

    initial begin
        int base;
        logic [7:0] b;

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // ---- reset state ----
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("rst");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // ---- T1: len 2, 0x1234, 0xABCD; XOR 02^12^34^AB^CD = 0x42 ----
        base = wr_addr_q.size();
        do_start();
        check("t1_busy_start", {31'd0, busy}, 32'd1);
        check("t1_rdy_start", {31'd0, byte_ready}, 32'd1);
        check("t1_state_start", {28'd0, dut.state}, {28'd0, LEN_HI});
        send_word(16'h0002, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        // One cycle after the low byte: write strobe with registered data.
        check("t1_we", {31'd0, mem_we}, 32'd1);
        check("t1_wdata", {16'd0, mem_wdata}, 32'h1234);
        check("t1_waddr", {24'd0, mem_addr}, 32'd0);
        check("t1_rdy_write", {31'd0, byte_ready}, 32'd0);
        check("t1_cpu_hold", {31'd0, cpu_resetn}, 32'd0);
        @(posedge clock);
        #1;
        check("t1_we_off", {31'd0, mem_we}, 32'd0);
        check("t1_addr_inc", {24'd0, mem_addr}, 32'd1);
        send_word(16'hABCD, 1'b0);
        @(posedge clock);
        #1;
        check("t1_busy_chk", {31'd0, busy}, 32'd1);
        send_byte(8'h42, 1'b0);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_error", {31'd0, error}, 32'd0);
        check("t1_cpu", {31'd0, cpu_resetn}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_rdy_end", {31'd0, byte_ready}, 32'd0);
        check("t1_addr_end", {24'd0, mem_addr}, 32'd2);
        check("t1_nwr", wr_addr_q.size() - base, 32'd2);
        check_write(base, 8'd0, 16'h1234);
        check_write(base + 1, 8'd1, 16'hABCD);

        // ---- T2: same image, bad checksum 0x41 ----
        base = wr_addr_q.size();
        do_start();
        check("t2_done_clr", {31'd0, done}, 32'd0);
        check("t2_cpu_clr", {31'd0, cpu_resetn}, 32'd0);
        send_word(16'h0002, 1'b0);
        send_word(16'h1234, 1'b0);
        send_word(16'hABCD, 1'b0);
        send_byte(8'h41, 1'b0);
        check("t2_error", {31'd0, error}, 32'd1);
        check("t2_done", {31'd0, done}, 32'd0);
        check("t2_cpu", {31'd0, cpu_resetn}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_nwr", wr_addr_q.size() - base, 32'd2);
        check_write(base, 8'd0, 16'h1234);
        check_write(base + 1, 8'd1, 16'hABCD);

        // ---- T3: oversize length 0x0101 ----
        base = wr_addr_q.size();
        do_start();
        send_word(16'h0101, 1'b0);
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_rdy", {31'd0, byte_ready}, 32'd0);
        check("t3_state", {28'd0, dut.state}, {28'd0, ERROR});
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (5) @(posedge clock);
        #1;
        byte_valid = 1'b0;
        check("t3_rdy_hold", {31'd0, byte_ready}, 32'd0);
        check("t3_err_hold", {31'd0, error}, 32'd1);
        check("t3_cpu", {31'd0, cpu_resetn}, 32'd0);
        check("t3_nwr", wr_addr_q.size() - base, 32'd0);

        // ---- T4: length 0, checksum 0x00 ----
        base = wr_addr_q.size();
        do_start();
        send_word(16'h0000, 1'b0);
        check("t4_state", {28'd0, dut.state}, {28'd0, CHK});
        send_byte(8'h00, 1'b0);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_cpu", {31'd0, cpu_resetn}, 32'd1);
        check("t4_nwr", wr_addr_q.size() - base, 32'd0);

        // ---- T5: 4 words with random stalls, start ignored mid-load ----
        // XOR: 00^04 ^ 01^02 ^ 03^04 ^ A5^A5 ^ 0F^00 = 0x0F
        base = wr_addr_q.size();
        do_start();
        send_word(16'h0004, 1'b1);
        send_word(16'h0102, 1'b1);
        send_word(16'h0304, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        do_start();
        check("t5_busy_mid", {31'd0, busy}, 32'd1);
        check("t5_state_mid", {28'd0, dut.state}, {28'd0, DATA_HI});
        check("t5_addr_mid", {24'd0, mem_addr}, 32'd2);
        send_word(16'hA5A5, 1'b1);
        send_word(16'h0F00, 1'b1);
        send_byte(8'h0F, 1'b1);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_cpu", {31'd0, cpu_resetn}, 32'd1);
        check("t5_nwr", wr_addr_q.size() - base, 32'd4);
        check_write(base, 8'd0, 16'h0102);
        check_write(base + 1, 8'd1, 16'h0304);
        check_write(base + 2, 8'd2, 16'hA5A5);
        check_write(base + 3, 8'd3, 16'h0F00);

        // ---- T6: full memory, length 0x0100, word i = {i, ~i} ----
        // Data bytes cancel pairwise over all 256 values, leaving 01^00 = 0x01.
        base = wr_addr_q.size();
        do_start();
        send_word(16'h0100, 1'b0);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            send_word({b, ~b}, 1'b0);
        end
        send_byte(8'h01, 1'b0);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_addr_wrap", {24'd0, mem_addr}, 32'd0);
        check("t6_nwr", wr_addr_q.size() - base, 32'd256);
        check_write(base, 8'h00, 16'h00FF);
        check_write(base + 255, 8'hFF, 16'hFF00);

        // ---- T7: async reset between hi and lo byte of word 3 ----
        do_start();
        send_word(16'h0004, 1'b0);
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_byte(8'h33, 1'b0);
        check("t7_state_pre", {28'd0, dut.state}, {28'd0, DATA_LO});
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t7_rst");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fresh load: len 2, 0xBEEF, 0x0001; XOR 02^BE^EF^00^01 = 0x52
        base = wr_addr_q.size();
        do_start();
        send_word(16'h0002, 1'b0);
        send_word(16'hBEEF, 1'b0);
        send_word(16'h0001, 1'b0);
        send_byte(8'h52, 1'b0);
        check("t7_done", {31'd0, done}, 32'd1);
        check("t7_cpu", {31'd0, cpu_resetn}, 32'd1);
        check("t7_nwr", wr_addr_q.size() - base, 32'd2);
        check_write(base, 8'd0, 16'hBEEF);
        check_write(base + 1, 8'd1, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
